// File: rtl/pipe_stage_reg.sv
//------------------------------------------------------------------------------
// Module      : pipe_stage_reg
// Description : Inter-stage pipeline register for the 5-stage MIPS core.
//               Registers one instruction's fields with a valid bit.
//               Supports stall (hold) and flush (bubble) control.
//               Counts Tnew down towards zero, saturating at zero.
//               Produces a registered-state forwarding-ready flag.
// Optional    : `define PIPE_STAGE_CNT_EN adds out_entry_cnt, a wrapping
//               count of valid entries loaded.
// Ports       : clk, reset (sync, active-high), stall, flush,
//               in_valid/in_pc8/in_instr/in_data/in_a3/in_ctrl/in_tnew,
//               out_valid/out_pc8/out_instr/out_data/out_a3/out_ctrl/out_tnew,
//               out_fwd_rdy, [out_entry_cnt]
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg #(
  parameter int DATA_W        = 32,
  parameter int CTRL_W        = 8,
  parameter int TNEW_W        = 2,
  parameter int TNEW_HOLD_DEC = 1,
  parameter int COUNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc8,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_a3,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  output logic [31:0]       out_pc8,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_a3,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [TNEW_W-1:0] out_tnew,
`ifdef PIPE_STAGE_CNT_EN
  output logic [COUNT_W-1:0] out_entry_cnt,
`endif
  output logic              out_fwd_rdy
);

  // Saturating decrement: Tnew never wraps below zero.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

  // Declaration initialisers give the reset values at power-on.
  logic              r_valid = 1'b0;
  logic [31:0]       r_pc8   = '0;
  logic [31:0]       r_instr = '0;
  logic [DATA_W-1:0] r_data  = '0;
  logic [4:0]        r_a3    = '0;
  logic [CTRL_W-1:0] r_ctrl  = '0;
  logic [TNEW_W-1:0] r_tnew  = '0;

  // A real load happens only on the plain load path with a valid input.
  logic w_load_valid;
  assign w_load_valid = !reset && !flush && !stall && in_valid;

  // Priority: reset > flush > stall > load. An invalid input on the load
  // path becomes a bubble, so a stale a3 can never look forwardable.
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !in_valid)) begin
      r_valid <= 1'b0;
      r_pc8   <= '0;
      r_instr <= '0;
      r_data  <= '0;
      r_a3    <= '0;
      r_ctrl  <= '0;
      r_tnew  <= '0;
    end else if (stall) begin
      // Fields hold; only Tnew may keep ageing while the stage is frozen.
      if (TNEW_HOLD_DEC != 0) begin
        r_tnew <= sat_dec(r_tnew);
      end
    end else begin
      r_valid <= 1'b1;
      r_pc8   <= in_pc8;
      r_instr <= in_instr;
      r_data  <= in_data;
      r_a3    <= in_a3;
      r_ctrl  <= in_ctrl;
      // in_tnew was measured at the previous stage; one stage has now passed.
      r_tnew  <= sat_dec(in_tnew);
    end
  end

`ifdef PIPE_STAGE_CNT_EN
  logic [COUNT_W-1:0] r_entry_cnt = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_entry_cnt <= '0;
    end else if (w_load_valid) begin
      r_entry_cnt <= r_entry_cnt + 1'b1;
    end
  end

  assign out_entry_cnt = r_entry_cnt;
`else
  // Without the counter the load qualifier has no consumer.
  logic w_unused;
  assign w_unused = w_load_valid;
`endif

  assign out_valid   = r_valid;
  assign out_pc8     = r_pc8;
  assign out_instr   = r_instr;
  assign out_data    = r_data;
  assign out_a3      = r_a3;
  assign out_ctrl    = r_ctrl;
  assign out_tnew    = r_tnew;
  // $0 is never a forwarding source; result must also be ready now.
  assign out_fwd_rdy = r_valid && (r_a3 != 5'd0) && (r_tnew == '0);

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none

module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [31:0] in_pc8, in_instr, in_data;
  logic [4:0]  in_a3;
  logic [7:0]  in_ctrl;
  logic [1:0]  in_tnew;

  logic        out_valid, out_fwd_rdy;
  logic [31:0] out_pc8, out_instr, out_data;
  logic [4:0]  out_a3;
  logic [7:0]  out_ctrl;
  logic [1:0]  out_tnew;

  logic        nd_valid, nd_fwd_rdy;
  logic [31:0] nd_pc8, nd_instr, nd_data;
  logic [4:0]  nd_a3;
  logic [7:0]  nd_ctrl;
  logic [1:0]  nd_tnew;
`ifdef PIPE_STAGE_CNT_EN
  logic [3:0]  out_entry_cnt, nd_entry_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Tnew decrements during stall.
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .TNEW_W(2), .TNEW_HOLD_DEC(1), .COUNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc8(in_pc8), .in_instr(in_instr), .in_data(in_data),
    .in_a3(in_a3), .in_ctrl(in_ctrl), .in_tnew(in_tnew),
    .out_valid(out_valid), .out_pc8(out_pc8), .out_instr(out_instr), .out_data(out_data),
    .out_a3(out_a3), .out_ctrl(out_ctrl), .out_tnew(out_tnew),
`ifdef PIPE_STAGE_CNT_EN
    .out_entry_cnt(out_entry_cnt),
`endif
    .out_fwd_rdy(out_fwd_rdy)
  );

  // Tnew frozen during stall.
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .TNEW_W(2), .TNEW_HOLD_DEC(0), .COUNT_W(4)) u_dut_nd (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc8(in_pc8), .in_instr(in_instr), .in_data(in_data),
    .in_a3(in_a3), .in_ctrl(in_ctrl), .in_tnew(in_tnew),
    .out_valid(nd_valid), .out_pc8(nd_pc8), .out_instr(nd_instr), .out_data(nd_data),
    .out_a3(nd_a3), .out_ctrl(nd_ctrl), .out_tnew(nd_tnew),
`ifdef PIPE_STAGE_CNT_EN
    .out_entry_cnt(nd_entry_cnt),
`endif
    .out_fwd_rdy(nd_fwd_rdy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc8, input logic [31:0] instr,
                       input logic [31:0] data, input logic [4:0] a3,
                       input logic [7:0] ctrl, input logic [1:0] tnew);
    in_valid = v; in_pc8 = pc8; in_instr = instr; in_data = data;
    in_a3 = a3; in_ctrl = ctrl; in_tnew = tnew;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_pc8"},   out_pc8,   0);
    check({tag, "_instr"}, out_instr, 0);
    check({tag, "_data"},  out_data,  0);
    check({tag, "_a3"},    out_a3,    0);
    check({tag, "_ctrl"},  out_ctrl,  0);
    check({tag, "_tnew"},  out_tnew,  0);
    check({tag, "_fwd"},   out_fwd_rdy, 0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h0000_0444, 32'h2222_3333, 32'h1234_5678, 5'd5, 8'hFF, 2'd1);
    #1;
    check("poweron_valid", out_valid, 0);
    check("poweron_fwd", out_fwd_rdy, 0);

    // 1: reset for two cycles with nonzero inputs
    step(); check_bubble("rst1");
    step(); check_bubble("rst2");
`ifdef PIPE_STAGE_CNT_EN
    check("rst_cnt", out_entry_cnt, 0);
`endif
    reset = 1'b0;

    // 2: load, Tnew 2 -> 1, then Tnew 0 -> forwardable
    drive(1'b1, 32'h0000_0100, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5, 8'hA5, 2'd2);
    step();
    check("ld_valid", out_valid, 1);
    check("ld_pc8", out_pc8, 32'h0000_0100);
    check("ld_instr", out_instr, 32'h0000_1234);
    check("ld_data", out_data, 32'hDEAD_BEEF);
    check("ld_a3", out_a3, 5);
    check("ld_ctrl", out_ctrl, 8'hA5);
    check("ld_tnew", out_tnew, 1);
    check("ld_fwd", out_fwd_rdy, 0);
    drive(1'b1, 32'h0000_0104, 32'h0000_5678, 32'h0000_0011, 5'd5, 8'h3C, 2'd0);
    step();
    check("ld0_tnew", out_tnew, 0);
    check("ld0_fwd", out_fwd_rdy, 1);
    check("ld0_data", out_data, 32'h0000_0011);
    drive(1'b1, 32'h0000_0108, 32'h0000_0000, 32'h0000_0022, 5'd0, 8'h01, 2'd1);
    step();
    check("a3zero_tnew", out_tnew, 0);
    check("a3zero_fwd", out_fwd_rdy, 0);

    // 3: stall three cycles after loading Tnew=3
    drive(1'b1, 32'h0000_0200, 32'h0BAD_F00D, 32'h00C0_FFEE, 5'd9, 8'h5A, 2'd3);
    step();
    check("st_tnew0", out_tnew, 2);
    check("st_nd_tnew0", nd_tnew, 2);
    stall = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 8'hFF, 2'd3);
    step();
    check("st_tnew1", out_tnew, 1);
    check("st_nd_tnew1", nd_tnew, 2);
    check("st_fwd1", out_fwd_rdy, 0);
    step();
    check("st_tnew2", out_tnew, 0);
    check("st_fwd2", out_fwd_rdy, 1);
    check("st_nd_fwd2", nd_fwd_rdy, 0);
    step();
    check("st_tnew3", out_tnew, 0);
    check("st_nd_tnew3", nd_tnew, 2);
    check("st_data", out_data, 32'h00C0_FFEE);
    check("st_pc8", out_pc8, 32'h0000_0200);
    check("st_instr", out_instr, 32'h0BAD_F00D);
    check("st_a3", out_a3, 9);
    check("st_ctrl", out_ctrl, 8'h5A);
    check("st_valid", out_valid, 1);
    check("st_nd_data", nd_data, 32'h00C0_FFEE);

    // 4: flush with stall and valid input -> bubble; then flush alone
    flush = 1'b1;
    step(); check_bubble("flst");
    check("flst_nd_valid", nd_valid, 0);
    stall = 1'b0;
    drive(1'b1, 32'h0000_0300, 32'h1111_1111, 32'h0000_0033, 5'd3, 8'h11, 2'd0);
    step(); check_bubble("fl");
    flush = 1'b0;

    // 5: invalid input -> bubble; reset during stall -> zeros
    drive(1'b0, 32'h0000_0400, 32'h4444_4444, 32'h0000_0055, 5'd7, 8'h77, 2'd2);
    step(); check_bubble("inv");
    drive(1'b1, 32'h0000_0500, 32'h5555_5555, 32'h0000_0066, 5'd4, 8'h44, 2'd0);
    step();
    check("pre_rst_fwd", out_fwd_rdy, 1);
    stall = 1'b1; reset = 1'b1;
    step(); check_bubble("rst_stall");
    reset = 1'b0;
    step(); check_bubble("stall_bub");
    stall = 1'b0;

`ifdef PIPE_STAGE_CNT_EN
    // 6: 17 valid loads interleaved with stalls, bubbles and flushes
    reset = 1'b1; step(); reset = 1'b0;
    check("cnt_rst", out_entry_cnt, 0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h1000 + i, 32'h0, 32'h0, 5'd1, 8'h0, 2'd0);
      step();
      if (i == 4) check("cnt_5", out_entry_cnt, 5);
      if (i == 14) check("cnt_wrap", out_entry_cnt, 15);
      if (i % 3 == 0) begin stall = 1'b1; step(); stall = 1'b0; end
      if (i % 3 == 1) begin in_valid = 1'b0; step(); end
      if (i % 4 == 2) begin in_valid = 1'b1; flush = 1'b1; step(); flush = 1'b0; end
    end
    check("cnt_17", out_entry_cnt, 1);
    check("cnt_nd_17", nd_entry_cnt, 1);
    stall = 1'b1; in_valid = 1'b1; step(); stall = 1'b0;
    check("cnt_stall", out_entry_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
